// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory handshake and IF/ID outputs.
// The master side belongs to the fetch stage; the slave side is memory, hazard unit, EXE and ID.
interface if_stage_fetch_if;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   modport master (
      input  freeze, branch_taken, branch_addr, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, if_pc, if_instr, if_valid
   );

   modport slave (
      output freeze, branch_taken, branch_addr, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, if_pc, if_instr, if_valid
   );
endinterface

// File: rtl/if_stage_fetch.sv
// PC, single-outstanding fetch FSM and IF/ID register; the word lands on IF/ID on the rvalid edge.
// Freeze holds IF/ID and parks a returned word in a one-entry buffer; branch_taken overrides freeze.
module if_stage_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   if_stage_fetch_if.master bus
);

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_pc_inc;
   logic        r_drop;
   logic        w_drop_nxt;
   logic [31:0] r_buf;
   logic [31:0] w_buf_nxt;
   logic        r_buf_vld;
   logic        w_buf_vld_nxt;
   ifid_t       r_ifid;
   ifid_t       w_ifid_nxt;
   ifid_t       w_ifid_idle;
   ifid_t       w_ifid_flush;

   assign w_pc_inc = r_pc + 32'd4;

   // With no new word, IF/ID either holds (freeze) or turns into a bubble keeping its pc.
   always_comb begin
      w_ifid_idle = r_ifid;
      if (!bus.freeze) begin
         w_ifid_idle.instr = NOP_INSTR;
         w_ifid_idle.valid = 1'b0;
      end
   end

   assign w_ifid_flush = '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_drop_nxt    = r_drop;
      w_buf_nxt     = r_buf;
      w_buf_vld_nxt = r_buf_vld;
      w_ifid_nxt    = r_ifid;

      if (bus.branch_taken) begin
         w_pc_nxt      = bus.branch_addr;
         w_ifid_nxt    = w_ifid_flush;
         w_buf_vld_nxt = 1'b0;
         case (r_state)
            // The request to the old pc still goes out; its response must be swallowed.
            ST_REQ: begin
               w_drop_nxt  = 1'b1;
               w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.imem_rvalid) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = ST_REQ;
               end else begin
                  w_drop_nxt  = 1'b1;
               end
            end
            default: begin
               w_drop_nxt  = 1'b0;
               w_state_nxt = ST_REQ;
            end
         endcase
      end else begin
         case (r_state)
            ST_REQ: begin
               w_ifid_nxt  = w_ifid_idle;
               w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               if (!bus.imem_rvalid) begin
                  w_ifid_nxt = w_ifid_idle;
               end else if (r_drop) begin
                  // pc already holds the redirect target, so it is not advanced here.
                  w_ifid_nxt  = w_ifid_idle;
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = ST_REQ;
               end else if (!bus.freeze) begin
                  w_ifid_nxt  = '{pc: w_pc_inc, instr: bus.imem_rdata, valid: 1'b1};
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = ST_REQ;
               end else begin
                  w_buf_nxt     = bus.imem_rdata;
                  w_buf_vld_nxt = 1'b1;
                  w_state_nxt   = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!bus.freeze) begin
                  w_ifid_nxt    = '{pc: w_pc_inc, instr: r_buf, valid: 1'b1};
                  w_pc_nxt      = w_pc_inc;
                  w_buf_vld_nxt = 1'b0;
                  w_state_nxt   = ST_REQ;
               end
            end
            default: begin
               w_state_nxt = ST_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_REQ;
         r_pc      <= RESET_PC;
         r_drop    <= 1'b0;
         r_buf     <= NOP_INSTR;
         r_buf_vld <= 1'b0;
         r_ifid    <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_drop    <= w_drop_nxt;
         r_buf     <= w_buf_nxt;
         r_buf_vld <= w_buf_vld_nxt;
         r_ifid    <= w_ifid_nxt;
      end
   end

   // Gating with rst keeps the request low while reset is held although the state is already REQ.
   assign bus.imem_req  = (r_state == ST_REQ) && rst;
   assign bus.imem_addr = r_pc;
   assign bus.if_pc     = r_ifid.pc;
   assign bus.if_instr  = r_ifid.instr;
   assign bus.if_valid  = r_ifid.valid;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: variable-latency memory responder, abstract fetch model checked every cycle,
// and directed scenarios with literal expectations.
module tb_if_stage_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        br = 1'b0;
   logic [31:0] baddr = 32'd0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        late_rvalid = 1'b0;
   int          mem_lat = 1;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // abstract model: outstanding fetch, stale flag, parked word, IF/ID contents
   bit          m_out, m_stale, m_held, m_valid, m_req_now;
   logic [31:0] m_pc, m_word, m_ifpc, m_instr;

   always #5 clk = ~clk;

   if_stage_fetch_if bus ();

   assign bus.freeze       = freeze;
   assign bus.branch_taken = br;
   assign bus.branch_addr  = baddr;
   assign bus.imem_rvalid  = mem_rvalid | late_rvalid;
   assign bus.imem_rdata   = late_rvalid ? 32'hBAD0_BAD0 : mem_rdata;

   if_stage_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'd0) ? 32'hE3A0_1001 : (a ^ 32'hE000_0000);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %08h expected %08h", nm, $time, act, exp);
      end
   endtask

   task automatic m_reset();
      m_out = 0; m_stale = 0; m_held = 0; m_valid = 0;
      m_pc = 32'd0; m_word = 32'd0; m_ifpc = 32'd0; m_instr = 32'd0;
   endtask

   task automatic m_bubble();
      if (!freeze) begin
         m_valid = 0;
         m_instr = 32'd0;
      end
   endtask

   task automatic m_deliver(input logic [31:0] w);
      m_ifpc  = m_pc + 32'd4;
      m_instr = w;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
   endtask

   // Model plus cycle counter (cycle 1 = the cycle in which rst is released).
   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_reset();
            cyc = 0;
         end else if (clk) begin
            cyc++;
            m_req_now = !m_out && !m_held;
            if (br) begin
               m_pc = baddr; m_ifpc = 32'd0; m_instr = 32'd0; m_valid = 0; m_held = 0;
               if (m_req_now) begin
                  m_out = 1; m_stale = 1;
               end else if (m_out && bus.imem_rvalid) begin
                  m_out = 0; m_stale = 0;
               end else if (m_out) begin
                  m_stale = 1;
               end
            end else if (m_req_now) begin
               m_out = 1;
               m_bubble();
            end else if (m_out) begin
               if (!bus.imem_rvalid) m_bubble();
               else begin
                  m_out = 0;
                  if (m_stale) begin
                     m_stale = 0;
                     m_bubble();
                  end else if (!freeze) m_deliver(bus.imem_rdata);
                  else begin
                     m_held = 1;
                     m_word = bus.imem_rdata;
                  end
               end
            end else if (!freeze) begin
               m_held = 0;
               m_deliver(m_word);
            end
         end
      end
   end

   // Memory: request seen at negedge, response strobe mem_lat cycles later.
   initial begin
      bit          pend;
      int          cnt;
      logic [31:0] paddr;
      pend = 0; cnt = 0; paddr = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (pend && rst) begin
            cnt--;
            if (cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_word(paddr);
               pend = 0;
            end
         end
         @(negedge clk);
         if (!rst) pend = 0;
         else if (bus.imem_req && !pend) begin
            pend = 1; cnt = mem_lat; paddr = bus.imem_addr;
         end
      end
   end

   task automatic compare_loop();
      bit er;
      forever begin
         @(negedge clk);
         er = rst && !m_out && !m_held;
         chk("imem_req", 32'(bus.imem_req), 32'(er));
         if (er) chk("imem_addr", bus.imem_addr, m_pc);
         chk("if_pc", bus.if_pc, m_ifpc);
         chk("if_instr", bus.if_instr, m_instr);
         chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
      end
   endtask

   task automatic goto(input int k);
      bit hit;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (cyc == k - 1) hit = 1;
      end
      if (!hit) begin
         n_cmp++;
         n_err++;
         $display("FAIL goto_timeout: cycle %0d not reached (counter %0d)", k, cyc + 1);
      end
   endtask

   task automatic at_start(input int k);
      goto(k - 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat, input bit b, input logic [31:0] ba, input bit late);
      rst = 1'b0; freeze = 1'b0; br = 1'b0; late_rvalid = 1'b0; mem_lat = lat;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1; br = b; baddr = ba; late_rvalid = late;
   endtask

   task automatic chk_ifid(input string nm, input logic [31:0] pc, input logic [31:0] ins, input bit v);
      chk({nm, "_pc"}, bus.if_pc, pc);
      chk({nm, "_instr"}, bus.if_instr, ins);
      chk({nm, "_valid"}, 32'(bus.if_valid), 32'(v));
   endtask

   task automatic chk_req(input string nm, input bit r, input logic [31:0] a);
      chk({nm, "_req"}, 32'(bus.imem_req), 32'(r));
      if (r) chk({nm, "_addr"}, bus.imem_addr, a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      fork
         compare_loop();
      join_none
      #1;

      // 1: reset release, latency 1
      do_reset(1, 1'b0, 32'd0, 1'b0);
      goto(1); chk_req("t1_c1", 1'b1, 32'd0); chk_ifid("t1_c1", 32'd0, 32'd0, 1'b0);
      goto(3); chk_ifid("t1_c3", 32'd4, 32'hE3A0_1001, 1'b1); chk_req("t1_c3", 1'b1, 32'd4);

      // 2: freeze over a WAIT response -> HOLD, release one cycle later
      do_reset(1, 1'b0, 32'd0, 1'b0);
      at_start(3); freeze = 1'b1;
      goto(5); chk_ifid("t2_c5", 32'd4, 32'hE3A0_1001, 1'b1); chk_req("t2_c5", 1'b0, 32'd0);
      @(posedge clk); #1; freeze = 1'b0;
      goto(6); chk_req("t2_c6", 1'b0, 32'd0);
      goto(7); chk_ifid("t2_c7", 32'd8, 32'hE000_0004, 1'b1); chk_req("t2_c7", 1'b1, 32'd8);

      // 3: branch in REQ with latency 3
      do_reset(3, 1'b1, 32'h0000_0100, 1'b0);
      goto(1); chk_req("t3_c1", 1'b1, 32'd0);
      @(posedge clk); #1; br = 1'b0;
      goto(4); chk_ifid("t3_c4", 32'd0, 32'd0, 1'b0);
      goto(5); chk_req("t3_c5", 1'b1, 32'h0000_0100); chk_ifid("t3_c5", 32'd0, 32'd0, 1'b0);
      goto(9); chk_ifid("t3_c9", 32'h0000_0104, 32'hE000_0100, 1'b1);

      // 4: branch and rvalid together in WAIT while frozen
      do_reset(1, 1'b0, 32'd0, 1'b0);
      at_start(3); freeze = 1'b1;
      at_start(4); br = 1'b1; baddr = 32'h0000_0200;
      goto(4); chk_ifid("t4_c4", 32'd4, 32'hE3A0_1001, 1'b1);
      @(posedge clk); #1; freeze = 1'b0; br = 1'b0;
      goto(5); chk_ifid("t4_c5", 32'd0, 32'd0, 1'b0); chk_req("t4_c5", 1'b1, 32'h0000_0200);
      goto(7); chk_ifid("t4_c7", 32'h0000_0204, 32'hE000_0200, 1'b1);

      // 5: pc wrap at the top of the address space
      do_reset(1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      @(posedge clk); #1; br = 1'b0;
      goto(3); chk_req("t5_c3", 1'b1, 32'hFFFF_FFFC);
      goto(5); chk_ifid("t5_c5", 32'd0, 32'h1FFF_FFFC, 1'b1); chk_req("t5_c5", 1'b1, 32'd0);

      // 6: asynchronous reset during WAIT, late response after release
      do_reset(1, 1'b0, 32'd0, 1'b0);
      at_start(3); mem_lat = 3; freeze = 1'b1;
      goto(4); chk_ifid("t6_pre", 32'd4, 32'hE3A0_1001, 1'b1);
      #2; rst = 1'b0;
      #1; chk_ifid("t6_async", 32'd0, 32'd0, 1'b0); chk_req("t6_async", 1'b0, 32'd0);
      do_reset(3, 1'b0, 32'd0, 1'b1);
      goto(1); chk_req("t6_c1", 1'b1, 32'd0);
      @(posedge clk); #1; late_rvalid = 1'b0;
      goto(2); chk_ifid("t6_c2", 32'd0, 32'd0, 1'b0);
      goto(5); chk_ifid("t6_c5", 32'd4, 32'hE3A0_1001, 1'b1);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 32-bit ARM pipeline. It holds the PC, issues fetches to a variable-latency instruction memory, and presents {pc+4, instruction, valid} to the ID stage. It consumes `hazard_detected` from the hazard unit as `freeze`, and the EXE-stage branch redirect as `branch_taken`/`branch_addr`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven on `if_instr` when the stage holds no valid instruction.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  stall request from the hazard unit (`hazard_detected`).
- branch_taken  in  1  redirect and flush request from EXE.
- branch_addr  in  32  redirect target.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  32  fetch address, valid while `imem_req` is 1.
- imem_rvalid  in  1  response strobe; latency is 1 or more cycles; at most one request outstanding.
- imem_rdata  in  32  instruction word, valid when `imem_rvalid` is 1.
- if_pc  out  32  registered PC+4 of the instruction on `if_instr`.
- if_instr  out  32  registered instruction for ID.
- if_valid  out  1  `if_instr` holds a real instruction.

Behaviour:
- Reset (asynchronous, `rst`=0):
  - pc=RESET_PC, state=REQ, drop=0, hold buffer invalid.
  - imem_req=0, if_pc=0, if_instr=NOP_INSTR, if_valid=0.
  - The first request is issued in the first cycle after `rst` deasserts.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req=1, imem_addr=pc. Next state is WAIT.
  - `imem_rvalid` is ignored in REQ.
  - IF/ID: if freeze=1, it holds; otherwise valid<=0 and instr<=NOP_INSTR (bubble).
- WAIT (imem_req=0):
  - No rvalid: same IF/ID rule as REQ.
  - rvalid and drop=1: discard the response, clear drop, go to REQ. pc is not incremented because it already holds the redirect target.
  - rvalid, drop=0, freeze=0: IF/ID<={pc+4, imem_rdata, 1}, pc<=pc+4, go to REQ.
  - rvalid, drop=0, freeze=1: IF/ID holds, imem_rdata goes into the hold buffer, go to HOLD.
- HOLD (imem_req=0):
  - While freeze=1, everything holds.
  - In the first cycle with freeze=0: IF/ID<={pc+4, buffer, 1}, pc<=pc+4, buffer invalid, go to REQ.
- Fetch latency: the instruction appears on IF/ID on the edge where rvalid is sampled, so minimum fetch-to-fetch spacing is 2 cycles.
- branch_taken=1 takes priority over freeze and over every state transition:
  - pc<=branch_addr.
  - IF/ID<={0, NOP_INSTR, 0}.
  - Hold buffer invalidated.
  - REQ state (a request to the old pc issues this cycle): drop<=1, go to WAIT.
  - WAIT state without rvalid: drop<=1, stay in WAIT.
  - WAIT state with rvalid in the same cycle: discard the response, drop<=0, go to REQ.
  - HOLD state: go to REQ.
- Only one `imem_req` pulse may be outstanding. No new request is issued until the response for the previous one is received, including responses that are to be dropped.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC plus 4 gives 0, and if_pc=0 for that instruction.
- `branch_addr` is used unmodified; no alignment check is performed.
- Reset asserted mid-operation forces reset values immediately. A response that arrives after reset lands in REQ and is ignored.

Test Plan:
1. Reset release with 1-cycle latency memory returning 32'hE3A0_1001 at address 0 -> imem_req at cycle 1 with addr 0; at the cycle-2 edge if_pc=4, if_instr=32'hE3A0_1001, if_valid=1; next request addr=4 at cycle 3.
2. freeze=1 for 3 cycles while a response arrives in WAIT -> IF/ID holds its prior value; entry to HOLD; one cycle after freeze drops, the buffered word appears with if_valid=1; no extra imem_req is issued during HOLD.
3. branch_taken=1 with branch_addr=32'h0000_0100 in REQ, memory latency 3 -> the returned old-pc word is discarded, if_valid stays 0; the next imem_addr is 32'h100; the following IF/ID entry has if_pc=32'h104.
4. branch_taken and imem_rvalid in the same WAIT cycle, with freeze=1 -> the response is discarded, IF/ID is flushed to NOP/valid 0 despite freeze, and the next imem_addr equals branch_addr.
5. PC at 32'hFFFF_FFFC, fetch completes -> if_pc=0; the next imem_addr is 0.
6. rst asserted asynchronously during WAIT, then a late rvalid arrives -> outputs reset immediately, the late response is ignored, and the first post-reset imem_addr is RESET_PC.
